elevator_call_dispatcher: RTL and testbench

//  Requester side of the floor-controller interface. Latches car/hall call buttons and drives the
//  one-hot requested_floor target that the floor-stepping controller tracks. Reads back the

---
 rtl/elevator_pkg.sv | 21 ++
 rtl/elevator_call_dispatcher_scan.sv | 61 ++++++
 rtl/elevator_call_dispatcher.sv | 151 +++++++++++++++
 tb/tb_elevator_call_dispatcher.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/elevator_pkg.sv
// Shared constants, FSM state type and one-hot helper for the elevator call dispatcher.
package elevator_pkg;

   localparam int DEFAULT_NUM_FLOORS = 4;

   localparam logic [3:0] FLOOR_0 = 4'b0001;
   localparam logic [3:0] FLOOR_1 = 4'b0010;
   localparam logic [3:0] FLOOR_2 = 4'b0100;
   localparam logic [3:0] FLOOR_3 = 4'b1000;

   typedef enum logic [1:0] {
      IDLE,
      MOVING,
      DWELL
   } disp_state_t;

   function automatic logic is_onehot(input logic [31:0] v);
      return (v != 32'd0) && ((v & (v - 32'd1)) == 32'd0);
   endfunction

endpackage

// File: rtl/elevator_call_dispatcher_scan.sv
// Combinational SCAN helper: nearest pending call above/below the current floor, and the
// target/direction SCAN would pick from here (keep direction, reverse only when nothing ahead).
module call_scan_select
   import elevator_pkg::*;
#(
   parameter int NUM_FLOORS = DEFAULT_NUM_FLOORS
) (
   input  logic [NUM_FLOORS-1:0] pending,
   input  logic [NUM_FLOORS-1:0] present,
   input  logic                  dir_up,
   output logic [NUM_FLOORS-1:0] nearest_above,
   output logic [NUM_FLOORS-1:0] nearest_below,
   output logic                  has_above,
   output logic                  has_below,
   output logic [NUM_FLOORS-1:0] next_target,
   output logic                  next_dir_up
);

   logic seen_lo;
   logic seen_hi;

   // Walk upward from the present floor; the first pending bit past it is the nearest above.
   always_comb begin
      nearest_above = '0;
      has_above     = 1'b0;
      seen_lo       = 1'b0;
      for (int i = 0; i < NUM_FLOORS; i++) begin
         if (seen_lo && pending[i] && !has_above) begin
            nearest_above[i] = 1'b1;
            has_above        = 1'b1;
         end
         if (present[i]) seen_lo = 1'b1;
      end
   end

   always_comb begin
      nearest_below = '0;
      has_below     = 1'b0;
      seen_hi       = 1'b0;
      for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
         if (seen_hi && pending[i] && !has_below) begin
            nearest_below[i] = 1'b1;
            has_below        = 1'b1;
         end
         if (present[i]) seen_hi = 1'b1;
      end
   end

   always_comb begin
      next_target = '0;
      next_dir_up = dir_up;
      if (dir_up) begin
         next_target = has_above ? nearest_above : nearest_below;
         next_dir_up = has_above;
      end else begin
         next_target = has_below ? nearest_below : nearest_above;
         next_dir_up = !has_below;
      end
   end

endmodule

// File: rtl/elevator_call_dispatcher.sv
// Latches call buttons and drives a one-hot SCAN-ordered target to the floor controller; door dwell per stop.
// Latency: lamps 1 cycle after press, new target 1 cycle after IDLE sees a call; DOOR_HOLD_EN adds door_hold.
// No backpressure: the floor controller tracks requested_floor; calls are never dropped, only served.
module elevator_call_dispatcher
   import elevator_pkg::*;
#(
   parameter int NUM_FLOORS  = DEFAULT_NUM_FLOORS,
   parameter int DWELL_TICKS = 3
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  tick,
   input  logic [NUM_FLOORS-1:0] call_btn,
   input  logic [NUM_FLOORS-1:0] present_floor,
   output logic [NUM_FLOORS-1:0] requested_floor,
   output logic [NUM_FLOORS-1:0] pending_calls,
   output logic                  door_open,
   output logic                  dir_up,
   output logic                  fault
`ifdef DOOR_HOLD_EN
   ,
   input  logic                  door_hold
`endif
);

   localparam int                    CW         = $clog2(DWELL_TICKS + 1);
   localparam logic [CW-1:0]         DWELL_LOAD = CW'(DWELL_TICKS);
   localparam logic [NUM_FLOORS-1:0] BOTTOM     = NUM_FLOORS'(1);

   disp_state_t           state_q, state_d;
   logic [NUM_FLOORS-1:0] req_q, req_d;
   logic [NUM_FLOORS-1:0] pend_q, pend_d;
   logic                  dir_q, dir_d;
   logic                  fault_q;
   logic [CW-1:0]         cnt_q, cnt_d;

   logic [NUM_FLOORS-1:0] scan_pending;
   logic [NUM_FLOORS-1:0] near_above, near_below, next_target;
   logic                  has_above, has_below, next_dir_up;
   logic [NUM_FLOORS-1:0] latch_mask, clr_mask;
   logic                  present_ok, press_here, hold_req, enter_dwell;

   assign present_ok = is_onehot(32'(present_floor));
   assign press_here = |(call_btn & present_floor);

`ifdef DOOR_HOLD_EN
   assign hold_req = door_hold | press_here;
`else
   assign hold_req = 1'b0;
`endif

   // While moving, a press this cycle may retarget immediately instead of waiting for the lamp.
   assign scan_pending = (state_q == MOVING) ? (pend_q | call_btn) : pend_q;

   call_scan_select #(
      .NUM_FLOORS (NUM_FLOORS)
   ) u_scan (
      .pending       (scan_pending),
      .present       (present_floor),
      .dir_up        (dir_q),
      .nearest_above (near_above),
      .nearest_below (near_below),
      .has_above     (has_above),
      .has_below     (has_below),
      .next_target   (next_target),
      .next_dir_up   (next_dir_up)
   );

   always_comb begin
      state_d     = state_q;
      req_d       = req_q;
      dir_d       = dir_q;
      cnt_d       = cnt_q;
      enter_dwell = 1'b0;
      latch_mask  = '1;
      if (!present_ok) begin
         state_d = IDLE;
         req_d   = BOTTOM;
         cnt_d   = '0;
      end else begin
         case (state_q)
            IDLE: begin
               req_d      = present_floor;
               latch_mask = ~present_floor;
               // A call left pending at this floor (e.g. across a fault) is served in place.
               if (press_here || |(pend_q & present_floor)) begin
                  enter_dwell = 1'b1;
               end else if (|pend_q) begin
                  state_d = MOVING;
                  req_d   = next_target;
                  dir_d   = next_dir_up;
               end
            end
            MOVING: begin
               if (present_floor == req_q) begin
                  enter_dwell = 1'b1;
               end else if (dir_q && has_above && (near_above < req_q)) begin
                  req_d = near_above;
               end else if (!dir_q && has_below && (near_below > req_q)) begin
                  req_d = near_below;
               end
            end
            DWELL: begin
               latch_mask = ~present_floor;
               if (hold_req) begin
                  cnt_d = DWELL_LOAD;
               end else if (tick) begin
                  if (cnt_q <= CW'(1)) begin
                     cnt_d   = '0;
                     state_d = IDLE;
                  end else begin
                     cnt_d = cnt_q - CW'(1);
                  end
               end
            end
            default: state_d = IDLE;
         endcase
      end
      if (enter_dwell) begin
         state_d = DWELL;
         cnt_d   = DWELL_LOAD;
      end
      clr_mask = enter_dwell ? present_floor : '0;
      pend_d   = (pend_q | (call_btn & latch_mask)) & ~clr_mask;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         req_q   <= BOTTOM;
         pend_q  <= '0;
         dir_q   <= 1'b1;
         fault_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         req_q   <= req_d;
         pend_q  <= pend_d;
         dir_q   <= dir_d;
         fault_q <= !present_ok;
         cnt_q   <= cnt_d;
      end
   end

   assign requested_floor = req_q;
   assign pending_calls   = pend_q;
   assign door_open       = (state_q == DWELL);
   assign dir_up          = dir_q;
   assign fault           = fault_q;

endmodule

// File: tb/tb_elevator_call_dispatcher.sv
// Directed bench for elevator_call_dispatcher (4 floors, 3-tick dwell); define DOOR_HOLD_EN to add the hold case.
module tb_elevator_call_dispatcher;

   logic       clk;
   logic       rst_n;
   logic       tick;
   logic [3:0] call_btn;
   logic [3:0] present_floor;
   logic [3:0] requested_floor;
   logic [3:0] pending_calls;
   logic       door_open;
   logic       dir_up;
   logic       fault;
`ifdef DOOR_HOLD_EN
   logic       door_hold;
`endif

   int n_checks;
   int n_fail;

   elevator_call_dispatcher #(
      .NUM_FLOORS  (4),
      .DWELL_TICKS (3)
   ) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .tick            (tick),
      .call_btn        (call_btn),
      .present_floor   (present_floor),
      .requested_floor (requested_floor),
      .pending_calls   (pending_calls),
      .door_open       (door_open),
      .dir_up          (dir_up),
      .fault           (fault)
`ifdef DOOR_HOLD_EN
      ,
      .door_hold       (door_hold)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b expected %b", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic tick_pulse();
      tick = 1'b1;
      step();
      tick = 1'b0;
   endtask

   task automatic restart(input logic [3:0] floor);
      present_floor = floor;
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      step();
   endtask

   initial begin
      n_checks      = 0;
      n_fail        = 0;
      rst_n         = 1'b0;
      tick          = 1'b0;
      call_btn      = 4'b0000;
      present_floor = 4'b0001;
`ifdef DOOR_HOLD_EN
      door_hold     = 1'b0;
`endif
      repeat (2) step();
      check("rst_requested", requested_floor, 4'b0001);
      check("rst_pending", pending_calls, 4'b0000);
      check("rst_door", {3'b0, door_open}, 4'b0000);
      check("rst_dir", {3'b0, dir_up}, 4'b0001);
      check("rst_fault", {3'b0, fault}, 4'b0000);
      rst_n = 1'b1;
      step();

      // Basic trip 0 -> 3, arrival coincides with a tick that must be ignored.
      call_btn = 4'b1000;
      step();
      call_btn = 4'b0000;
      check("trip_lamp", pending_calls, 4'b1000);
      check("trip_req_before", requested_floor, 4'b0001);
      step();
      check("trip_req", requested_floor, 4'b1000);
      check("trip_dir", {3'b0, dir_up}, 4'b0001);
      present_floor = 4'b0010;
      step();
      present_floor = 4'b0100;
      step();
      check("trip_held", requested_floor, 4'b1000);
      check("trip_door_closed", {3'b0, door_open}, 4'b0000);
      present_floor = 4'b1000;
      tick_pulse();
      check("trip_door_open", {3'b0, door_open}, 4'b0001);
      check("trip_cleared", pending_calls, 4'b0000);
      tick_pulse();
      tick_pulse();
      check("trip_dwell_2", {3'b0, door_open}, 4'b0001);
      tick_pulse();
      check("trip_dwell_end", {3'b0, door_open}, 4'b0000);

      // En-route pickup: heading for 3 from 1, floor 2 pressed on the way.
      restart(4'b0010);
      call_btn = 4'b1000;
      step();
      call_btn = 4'b0000;
      step();
      check("pickup_req_far", requested_floor, 4'b1000);
      call_btn = 4'b0100;
      step();
      call_btn = 4'b0000;
      check("pickup_retarget", requested_floor, 4'b0100);
      check("pickup_pending", pending_calls, 4'b1100);
      present_floor = 4'b0100;
      step();
      check("pickup_door", {3'b0, door_open}, 4'b0001);
      check("pickup_keep_far", pending_calls, 4'b1000);
      repeat (3) tick_pulse();
      check("pickup_dwell_end", {3'b0, door_open}, 4'b0000);
      step();
      check("pickup_resume", requested_floor, 4'b1000);
      present_floor = 4'b1000;
      step();
      check("pickup_served", pending_calls, 4'b0000);
      repeat (3) tick_pulse();

      // SCAN order from floor 2 going up with calls at 0 and 3.
      restart(4'b0100);
      call_btn = 4'b1001;
      step();
      call_btn = 4'b0000;
      check("scan_pending", pending_calls, 4'b1001);
      step();
      check("scan_first", requested_floor, 4'b1000);
      check("scan_dir_up", {3'b0, dir_up}, 4'b0001);
      present_floor = 4'b1000;
      step();
      check("scan_left", pending_calls, 4'b0001);
      repeat (3) tick_pulse();
      step();
      check("scan_second", requested_floor, 4'b0001);
      check("scan_dir_down", {3'b0, dir_up}, 4'b0000);
      present_floor = 4'b0100;
      step();
      present_floor = 4'b0010;
      step();
      present_floor = 4'b0001;
      step();
      check("scan_done_door", {3'b0, door_open}, 4'b0001);
      check("scan_done_pend", pending_calls, 4'b0000);
      repeat (3) tick_pulse();

      // Same-floor call while IDLE at floor 1.
      present_floor = 4'b0010;
      step();
      check("same_track", requested_floor, 4'b0010);
      call_btn = 4'b0010;
      step();
      check("same_door", {3'b0, door_open}, 4'b0001);
      check("same_no_lamp", pending_calls, 4'b0000);
      step();
      call_btn = 4'b0000;
      check("same_dwell_no_lamp", pending_calls, 4'b0000);
      tick_pulse();
      tick_pulse();
      check("same_dwell_2", {3'b0, door_open}, 4'b0001);
      tick_pulse();
      check("same_dwell_end", {3'b0, door_open}, 4'b0000);

      // Fault on multi-hot present_floor while moving; pending call survives.
      call_btn = 4'b1000;
      step();
      call_btn = 4'b0000;
      step();
      check("fault_pre_dir", {3'b0, dir_up}, 4'b0001);
      present_floor = 4'b0110;
      step();
      check("fault_flag", {3'b0, fault}, 4'b0001);
      check("fault_req", requested_floor, 4'b0001);
      check("fault_pending", pending_calls, 4'b1000);
      check("fault_door", {3'b0, door_open}, 4'b0000);
      present_floor = 4'b0010;
      step();
      check("fault_clear", {3'b0, fault}, 4'b0000);
      check("fault_redispatch", requested_floor, 4'b1000);

      // Asynchronous reset mid-trip clears state without a clock edge.
      #1 rst_n = 1'b0;
      #1;
      check("arst_req", requested_floor, 4'b0001);
      check("arst_pending", pending_calls, 4'b0000);
      check("arst_dir", {3'b0, dir_up}, 4'b0001);
      check("arst_fault", {3'b0, fault}, 4'b0000);
      rst_n = 1'b1;
      step();

`ifdef DOOR_HOLD_EN
      present_floor = 4'b0010;
      step();
      call_btn  = 4'b0010;
      door_hold = 1'b1;
      step();
      call_btn  = 4'b0000;
      check("hold_open", {3'b0, door_open}, 4'b0001);
      repeat (5) tick_pulse();
      check("hold_5", {3'b0, door_open}, 4'b0001);
      door_hold = 1'b0;
      tick_pulse();
      tick_pulse();
      check("hold_5p2", {3'b0, door_open}, 4'b0001);
      tick_pulse();
      check("hold_end", {3'b0, door_open}, 4'b0000);
`endif

      $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
      $finish;
   end

endmodule
